// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit.
// Ports: req_* (NREQ packed requests), rsp_* (single-entry tagged result).
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  rsp_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] data_q;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic             slot_free;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] data_d;

  assign slot_free = (state_q == EMPTY) | rsp_ready;

  // Search starts at the pointer; IDW-bit add wraps NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + IDW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept = found & slot_free;

  always_comb begin
    req_ready = '0;
    op_sel    = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        req_ready[i] = accept;
        op_sel       = req_op[2*i +: 2];
        a_sel        = req_a[WIDTH*i +: WIDTH];
        b_sel        = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d = '0;
    unique case (op_sel)
      2'b00: data_d = a_sel & b_sel;
      2'b01: data_d = a_sel | b_sel;
      2'b10: data_d = a_sel ^ b_sel;
      2'b11: data_d = ~(a_sel | b_sel);
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= data_d;
        id_q   <= win;
        ptr_q  <= win + 1'b1;
      end
      unique case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (rsp_ready && !accept) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter.
// Hand-computed vectors, immediate-assertion checks.
module tb_logic_unit_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [7:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ready;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] exp_op [4];

  logic_unit_arbiter #(.NREQ(4), .WIDTH(32), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_op[0] = 32'hAAAA_0000;
    exp_op[1] = 32'hFFFF_5555;
    exp_op[2] = 32'h5555_5555;
    exp_op[3] = 32'h0000_AAAA;

    rst_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    #1 rst_n = 1'b1;

    // single AND from requester 2
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'hF0F0_1234;
    req_b[64 +: 32] = 32'h0FF0_FFFF;
    rsp_ready = 1'b1;
    #1;
    chk("and_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("and_valid", 32'(rsp_valid), 32'd1);
    chk("and_id", 32'(rsp_id), 32'd2);
    chk("and_data", rsp_data, 32'h00F0_1234);
    step();
    chk("consume_valid", 32'(rsp_valid), 32'd0);
    chk("consume_hold", rsp_data, 32'h00F0_1234);

    // all opcodes on requester 0
    req_a = {4{32'hAAAA_5555}};
    req_b = {4{32'hFFFF_0000}};
    for (int op = 0; op < 4; op++) begin
      req_valid = 4'b0001;
      req_op[1:0] = 2'(op);
      step();
      chk("op_id", 32'(rsp_id), 32'd0);
      chk("op_data", rsp_data, exp_op[op]);
    end

    // reset while a result is pending
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    #1 rst_n = 1'b1;

    // round robin, requester i uses opcode i
    req_op = 8'hE4;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(i % 4));
      chk("rr_data", rsp_data, exp_op[i % 4]);
    end

    // back-pressure, pointer now 0
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd3);
      chk("bp_data", rsp_data, 32'h0000_AAAA);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready0", 32'(req_ready), 32'h1);
    step();
    chk("rel_id0", 32'(rsp_id), 32'd0);
    chk("rel_data0", rsp_data, 32'hAAAA_0000);
    chk("rel_ready1", 32'(req_ready), 32'h2);
    step();
    chk("rel_id1", 32'(rsp_id), 32'd1);
    chk("rel_data1", rsp_data, 32'hFFFF_5555);

    // consume and accept together
    req_valid = 4'b1000;
    #1;
    chk("ca_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    chk("ca_valid", 32'(rsp_valid), 32'd1);
    chk("ca_id", 32'(rsp_id), 32'd3);
    chk("ca_data", rsp_data, 32'h0000_AAAA);
    step();
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_id", 32'(rsp_id), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/XOR/NOR) among NREQ requesters.
- Each requester hands over a valid/ready request with two operands and an opcode.
- The block grants one requester per cycle in round-robin order and returns a tagged result through a single-entry output register with its own valid/ready handshake.
- It sits between the pre-lab logic datapath and its upstream clients.

Parameters:
- NREQ, 4, number of requesters (power of 2, 2..8).
- WIDTH, 32, operand/result width in bits.
- IDW, 2, requester-id width; must equal log2(NREQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i set: requester i presents a request.
- req_op  input  2*NREQ  opcode of requester i in bits [2i+1:2i]; 00=AND, 01=OR, 10=XOR, 11=NOR.
- req_a  input  WIDTH*NREQ  operand A of requester i in bits [WIDTH*(i+1)-1:WIDTH*i].
- req_b  input  WIDTH*NREQ  operand B, same packing as req_a.
- req_ready  output  NREQ  one-hot or zero; bit i set: request i accepted this cycle.
- rsp_valid  output  1  result register holds an unconsumed result.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_data  output  WIDTH  registered result.
- rsp_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): rsp_valid=0, rsp_id=0, rsp_data=0, priority pointer=0 (requester 0 highest).
  - Any in-flight result is discarded.
  - req_ready is combinational and is therefore 0 while rsp_valid=0 and req_valid=0.
- Slot free: slot_free = ~rsp_valid | rsp_ready.
- Grant: combinational round-robin search over req_valid, starting at the pointer and wrapping NREQ-1 -> 0.
  - The first set bit wins.
  - req_ready[win] = slot_free; all other req_ready bits are 0.
  - No valid requests: req_ready = 0.
- Accept (req_valid[i] & req_ready[i]) at edge k:
  - rsp_data <= f(op_i, a_i, b_i); rsp_id <= i; rsp_valid <= 1.
  - The result is visible after edge k, i.e. one cycle latency.
  - Pointer <= (i+1) mod NREQ.
- Output handshake: the result is consumed when rsp_valid & rsp_ready.
  - Consume with no simultaneous accept: rsp_valid <= 0; rsp_id and rsp_data hold their old values.
  - Consume and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1. This gives full throughput of one result per cycle.
- Back-pressure: while rsp_valid=1 and rsp_ready=0, all req_ready=0 and rsp_id, rsp_data and rsp_valid stay stable.
- Pointer rule: the pointer changes only on an accept. Back-pressure never changes priority.
- Requester rules: a requester keeps req_valid high and its op/a/b stable until accepted. A requester may drop req_valid only if it was not granted; the arbiter must tolerate this because the grant is re-evaluated every cycle.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,2,...,NREQ-1,0.
  - No requester waits more than NREQ-1 accepts.
- Arithmetic: purely bitwise, no carries. NOR = ~(a|b) over the full WIDTH.
- Structure: one-state-bit controller, EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on hold, or on consume+accept.

Test Plan:
- Reset mid-stream: rst_n low while rsp_valid=1 -> rsp_valid, rsp_id and rsp_data go to 0 before the next clk edge; after release, the first grant with all requesters valid goes to requester 0.
- Single request, AND: requester 2 valid, op=00, a=32'hF0F0_1234, b=32'h0FF0_FFFF, rsp_ready=1 -> req_ready=4'b0100; the next cycle shows rsp_valid=1, rsp_id=2, rsp_data=32'h00F0_1234.
- All opcodes: requester 0 with a=32'hAAAA_5555, b=32'hFFFF_0000 -> AND gives 32'hAAAA_0000, OR 32'hFFFF_5555, XOR 32'h5555_5555, NOR 32'h0000_AAAA.
- Round robin: req_valid=4'b1111 held, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with rsp_valid=1 every cycle after the first.
- Back-pressure: result pending, rsp_ready=0 for 3 cycles, req_valid=4'b0011 -> req_ready=0 and rsp_* stable for all 3 cycles; the pointer is unchanged, so on release the next grant is (previous id+1) among the valid requesters.
- Simultaneous consume and accept: rsp_valid=1 with id=1, rsp_ready=1, requester 3 the only valid -> req_ready=4'b1000 in the same cycle; the next cycle shows rsp_valid=1 and rsp_id=3, with no idle bubble.
